// File: rtl/io_input_debounce_if.sv
// Pin-side and core-side signals of io_input_debounce, grouped for port binding.
// latch_out/latch_clr exist only when IO_DEBOUNCE_LATCH_EN is defined.
interface io_input_debounce_if #(
   parameter int NI = 4
);
   logic [NI-1:0] pin_in;
   logic [NI-1:0] level_out;
   logic [NI-1:0] rise_out;
   logic [NI-1:0] fall_out;
   logic          tick_out;
`ifdef IO_DEBOUNCE_LATCH_EN
   logic [NI-1:0] latch_out;
   logic [NI-1:0] latch_clr;

   modport slave (
      input  pin_in, latch_clr,
      output level_out, rise_out, fall_out, tick_out, latch_out
   );
   modport master (
      output pin_in, latch_clr,
      input  level_out, rise_out, fall_out, tick_out, latch_out
   );
`else
   modport slave (
      input  pin_in,
      output level_out, rise_out, fall_out, tick_out
   );
   modport master (
      output pin_in,
      input  level_out, rise_out, fall_out, tick_out
   );
`endif
endinterface

// File: rtl/io_input_debounce.sv
// Synchronise, normalise and debounce NI slow pins into clean levels plus rise/fall strobes; IO_DEBOUNCE_LATCH_EN adds sticky rise flags.
// Latency 2 sync + (DB_TICKS-1)*CLK_DIV+1..DB_TICKS*CLK_DIV + 1 output clk; no backpressure, outputs are free-running.
module io_input_debounce #(
   parameter int            NI       = 4,
   parameter logic [NI-1:0] INV      = '0,
   parameter int            CLK_DIV  = 76800,
   parameter int            DB_TICKS = 5
) (
   input  logic               clk,
   input  logic               rst,
   io_input_debounce_if.slave io
);
   localparam int            PW       = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
   localparam logic [7:0]    CNT_LAST = 8'(DB_TICKS - 1);

   typedef enum logic [1:0] {S_LO, S_PEND_HI, S_HI, S_PEND_LO} state_t;

   logic [PW-1:0] pre_q;
   logic          tick;
   logic [NI-1:0] sync1_q;
   logic [NI-1:0] sync2_q;
   logic [NI-1:0] s;
   state_t        st_q  [NI];
   state_t        st_d  [NI];
   logic [7:0]    cnt_q [NI];
   logic [7:0]    cnt_d [NI];
   logic [NI-1:0] level_q, level_d;
   logic [NI-1:0] rise_q, rise_d;
   logic [NI-1:0] fall_q, fall_d;

   // One prescaler paces every channel so acceptances line up on common ticks.
   assign tick = (pre_q == PRE_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q <= '0;
      end else if (tick) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + PW'(1);
      end
   end

   // Sync flops reset to INV so the normalised sample starts inactive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= INV;
         sync2_q <= INV;
      end else begin
         sync1_q <= io.pin_in;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q ^ INV;

   always_comb begin
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < NI; i++) begin
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
         case (st_q[i])
            S_LO: begin
               if (s[i]) begin
                  st_d[i]  = S_PEND_HI;
                  cnt_d[i] = '0;
               end
            end
            S_PEND_HI: begin
               // A bounce wins over a coincident tick: that tick is discarded.
               if (!s[i]) begin
                  st_d[i]  = S_LO;
                  cnt_d[i] = '0;
               end else if (tick) begin
                  if (cnt_q[i] == CNT_LAST) begin
                     st_d[i]    = S_HI;
                     cnt_d[i]   = '0;
                     level_d[i] = 1'b1;
                     rise_d[i]  = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + 8'd1;
                  end
               end
            end
            S_HI: begin
               if (!s[i]) begin
                  st_d[i]  = S_PEND_LO;
                  cnt_d[i] = '0;
               end
            end
            S_PEND_LO: begin
               if (s[i]) begin
                  st_d[i]  = S_HI;
                  cnt_d[i] = '0;
               end else if (tick) begin
                  if (cnt_q[i] == CNT_LAST) begin
                     st_d[i]    = S_LO;
                     cnt_d[i]   = '0;
                     level_d[i] = 1'b0;
                     fall_d[i]  = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + 8'd1;
                  end
               end
            end
            default: begin
               st_d[i]  = S_LO;
               cnt_d[i] = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int i = 0; i < NI; i++) begin
            st_q[i]  <= S_LO;
            cnt_q[i] <= '0;
         end
      end else begin
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         for (int i = 0; i < NI; i++) begin
            st_q[i]  <= st_d[i];
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign io.level_out = level_q;
   assign io.rise_out  = rise_q;
   assign io.fall_out  = fall_q;
   assign io.tick_out  = tick;

`ifdef IO_DEBOUNCE_LATCH_EN
   logic [NI-1:0] latch_q;

   // Set term is OR-ed after the clear so a same-cycle rise is never lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         latch_q <= '0;
      end else begin
         latch_q <= (latch_q & ~io.latch_clr) | rise_q;
      end
   end

   assign io.latch_out = latch_q;
`endif
endmodule

// File: doc/io_input_debounce.md
Name: io_input_debounce

Overview:
- Conditions slow front-panel and board-edge inputs before they reach hermeslite_core: tx inhibit (CN8), phone tip (PTT/key), phone ring, and ATU ack.
- Per input: 2-FF synchronizer, polarity normalisation, tick-based debounce state machine.
- Outputs are a clean active-high level plus single-cycle rise/fall strobes.
- Sits between the top-level variant pins and the core inputs, in the clk domain.

Parameters:
- NI, 4, number of independent input channels.
- INV, 4'b0000, per-channel invert mask; bit set = pin active-low.
- CLK_DIV, 76800, clk cycles per debounce tick (1 ms at 76.8 MHz); legal range 2..2^20.
- DB_TICKS, 5, consecutive stable ticks required to accept a level change; legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- pin_in  in  NI  raw asynchronous pin levels.
- level_out  out  NI  debounced active-high level.
- rise_out  out  NI  one-clk pulse when level_out goes 0->1.
- fall_out  out  NI  one-clk pulse when level_out goes 1->0.
- tick_out  out  1  one-clk pulse on each prescaler tick, for test and for core timers.

Behaviour:
- Reset: clk and rst only, as stated. rst is asynchronous, active-high.
- Reset values: level_out=0, rise_out=0, fall_out=0, tick_out=0, prescaler=0, all channels in S_LO with count=0.
- Synchronizer FFs reset to INV[i], so the normalised sample is 0 at reset and no spurious edge appears on release.
- Synchronizer: 2 flops per channel. Normalised sample s[i] = sync2[i] ^ INV[i].
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - tick_out=1 in the cycle the counter equals CLK_DIV-1.
  - A single prescaler is shared by all channels.
- Per-channel FSM, states S_LO, S_PEND_HI, S_HI, S_PEND_LO; 8-bit count.
  - S_LO: if s=1, go to S_PEND_HI with count=0.
  - S_PEND_HI:
    - s=0 returns to S_LO, count=0, no output change.
    - Else on tick, count++.
    - When count reaches DB_TICKS (tick and count==DB_TICKS-1): go to S_HI, level_out<=1, rise_out pulses 1 cycle.
  - S_HI / S_PEND_LO: symmetric to the above, with fall_out pulsing.
- Sample/tick coincidence: s is evaluated before the tick in the same cycle. A bounce in a tick cycle resets the count, and that tick is not counted.
- Debounce latency:
  - First tick after entering a pending state may be partial, so acceptance takes between (DB_TICKS-1)*CLK_DIV+1 and DB_TICKS*CLK_DIV clk after s changes.
  - Plus 2 synchronizer cycles.
  - Plus 1 registered-output cycle.
- rise_out/fall_out are registered and coincide with the level_out change cycle. They are never both 1 on the same channel.
- Channels are fully independent. Simultaneous acceptance on several channels is allowed.
- Pulses shorter than one full debounce window are never propagated.
- Reset mid-operation: all state is cleared asynchronously and no pulse is emitted. After release, an input held active is accepted as a fresh rise.
- Count saturation: count never exceeds DB_TICKS; no wrap-around is possible.

Optional Feature:
- Macro: IO_DEBOUNCE_LATCH_EN.
- When defined, adds:
  - ports latch_out (out, NI) and latch_clr (in, NI);
  - sticky per-channel flag set by rise_out.
- latch_clr[i] clears bit i on the next clk.
- If set and clear occur in the same cycle, set wins, so no event is lost.
- latch_out resets to 0.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Bench settings: CLK_DIV=4, DB_TICKS=3, INV=4'b0001.
- Clean assert: pin_in[1] 0->1 and held. Required: level_out[1]=1 within 2+12+1 clk (≥2+9+1), exactly one rise_out[1] pulse, tick_out every 4 clk.
- Bounce reject: pin_in[2] toggles high for 6 clk, low for 2, high for 6, then low. Required: level_out[2] stays 0, no rise_out, FSM returns to S_LO.
- Active-low channel: pin_in[0]=1 from reset gives level_out[0]=0. Driving pin_in[0]=0 gives level_out[0]=1 after debounce. Restoring it to 1 gives exactly one fall_out[0] pulse.
- Simultaneous: pin_in[3:1] asserted on the same clk. Required: rise_out[3:1]=3'b111 in the same cycle.
- Reset mid-pending: pin_in[1] high, then rst pulsed after 7 clk. Required: all outputs 0 during reset, no pulse. After release with the pin still high, rise_out[1] fires a full window later.
- With IO_DEBOUNCE_LATCH_EN: rise and latch_clr in the same cycle leave latch_out[1]=1. latch_clr alone on the next clk gives latch_out[1]=0.
